// File: rtl/mat_pkg.sv
// Shared matrix-coprocessor package: dimensions, row/matrix types and the
// streamer state encoding. Operation units import the same definitions.
package mat_pkg;

  localparam int N      = 5;
  localparam int ELEM_W = 8;
  localparam int ROW_W  = N * ELEM_W;   // 40
  localparam int MAT_W  = N * ROW_W;    // 200
  localparam int IDX_W  = 3;

  typedef logic [ELEM_W-1:0] elem_t;
  typedef logic [ROW_W-1:0]  row_t;
  typedef logic [MAT_W-1:0]  mat_t;
  typedef logic [IDX_W-1:0]  idx_t;

  localparam idx_t LAST_IDX = idx_t'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/mat_row_streamer_if.sv
// Row-beat bus between the streamer (master) and the HPS-facing consumer.
//
// Handshake: a beat transfers on a rising edge where row_valid && row_ready.
// Once row_valid is high it stays high, and row_data/row_idx/row_last stay
// stable, until that beat transfers. row_ready may change freely.
interface mat_row_streamer_if;
  import mat_pkg::*;

  logic row_valid;
  logic row_ready;
  row_t row_data;
  idx_t row_idx;
  logic row_last;

  modport master (
    output row_valid,
    output row_data,
    output row_idx,
    output row_last,
    input  row_ready
  );

  modport slave (
    input  row_valid,
    input  row_data,
    input  row_idx,
    input  row_last,
    output row_ready
  );

endinterface

// File: rtl/mat_beat_select.sv
// Combinational beat slicer: picks beat i_idx out of the captured matrix.
// Build option MAT_ROW_STREAMER_COLMAJOR_EN: beat j is column j, with
// matrix[i][j] placed at element position i; otherwise beat j is row j.
module mat_beat_select
  import mat_pkg::*;
(
  input  mat_t i_buf,
  input  idx_t i_idx,
  output row_t o_beat
);

  // Select the row (or column) addressed by i_idx; out-of-range gives zero.
  always_comb begin
    o_beat = '0;
    for (int j = 0; j < N; j++) begin
      if (i_idx == idx_t'(j)) begin
`ifdef MAT_ROW_STREAMER_COLMAJOR_EN
        for (int i = 0; i < N; i++) begin
          o_beat[ROW_W-1-ELEM_W*i -: ELEM_W] =
            i_buf[MAT_W-1-ROW_W*i-ELEM_W*j -: ELEM_W];
        end
`else
        o_beat = i_buf[MAT_W-1-ROW_W*j -: ROW_W];
`endif
      end
    end
  end

endmodule

// File: rtl/mat_row_streamer.sv
// Output streamer: captures a 5x5 result matrix plus overflow flag on start,
// then sends it one 40-bit beat per handshake, followed by a one-cycle done.
// Optional build macro MAT_ROW_STREAMER_COLMAJOR_EN (column-major beats) is
// handled inside mat_beat_select.
module mat_row_streamer
  import mat_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  mat_t                       m_in,
  input  logic                       ovf_in,
  mat_row_streamer_if.master         row_if,
  output logic                       busy,
  output logic                       done,
  output logic                       ovf_out,
  output state_t                     dbg_state
);

  state_t r_state;
  state_t w_state_nxt;
  idx_t   r_idx;
  mat_t   r_buf;
  logic   r_ovf;
  logic   w_capture;
  logic   w_advance;
  logic   w_valid;
  logic   w_hs;
  row_t   w_beat;

  assign w_valid = (r_state == SEND);
  assign w_hs    = w_valid && row_if.row_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and capture/advance strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_capture   = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (w_hs) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = FIN;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      FIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Matrix buffer, overflow flag and beat index; buffer only loads in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf <= '0;
      r_ovf <= 1'b0;
      r_idx <= '0;
    end else if (w_capture) begin
      r_buf <= m_in;
      r_ovf <= ovf_in;
      r_idx <= '0;
    end else if (w_advance) begin
      r_idx <= r_idx + idx_t'(1);
    end
  end

  mat_beat_select u_beat_select (
    .i_buf  (r_buf),
    .i_idx  (r_idx),
    .o_beat (w_beat)
  );

  assign row_if.row_valid = w_valid;
  assign row_if.row_data  = w_beat;
  assign row_if.row_idx   = r_idx;
  assign row_if.row_last  = w_valid && (r_idx == LAST_IDX);
  assign busy             = w_valid;
  assign done             = (r_state == FIN);
  assign ovf_out          = r_ovf;
  assign dbg_state        = r_state;

endmodule

// File: tb/tb_mat_row_streamer.sv
// Bench for mat_row_streamer: vector table, hand-written corner sequences and
// randomized transfers against a matrix-level reference model.
module tb_mat_row_streamer;
  import mat_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   start = 1'b0;
  mat_t   m_in = '0;
  logic   ovf_in = 1'b0;
  logic   busy;
  logic   done;
  logic   ovf_out;
  state_t dbg_state;

  mat_row_streamer_if row_if();

  mat_row_streamer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .m_in      (m_in),
    .ovf_in    (ovf_in),
    .row_if    (row_if.master),
    .busy      (busy),
    .done      (done),
    .ovf_out   (ovf_out),
    .dbg_state (dbg_state)
  );

  // Clock / global time limit
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete, got running required finished");
    $fatal(1, "timeout");
  end

  // Scoreboard state
  int   n_checks = 0;
  int   n_errors = 0;
  row_t exp_q[$];
  int   hs_count = 0;
  row_t got_beats[N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: element (r,c) of the matrix, and beat j as a whole.
  function automatic elem_t elem_at(input mat_t m, input int r, input int c);
    return m[MAT_W-1-ROW_W*r-ELEM_W*c -: ELEM_W];
  endfunction

  function automatic row_t model_beat(input mat_t m, input int j);
    row_t b;
    b = '0;
    for (int i = 0; i < N; i++) begin
`ifdef MAT_ROW_STREAMER_COLMAJOR_EN
      b[ROW_W-1-ELEM_W*i -: ELEM_W] = elem_at(m, i, j);
`else
      b[ROW_W-1-ELEM_W*i -: ELEM_W] = elem_at(m, j, i);
`endif
    end
    return b;
  endfunction

  function automatic mat_t mat_rule10();
    mat_t m;
    m = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m[MAT_W-1-ROW_W*r-ELEM_W*c -: ELEM_W] = elem_t'(10 * r + c);
    return m;
  endfunction

  function automatic mat_t mat_random();
    mat_t m;
    m = '0;
    for (int e = 0; e < N * N; e++) m[ELEM_W*e +: ELEM_W] = elem_t'($urandom_range(0, 255));
    return m;
  endfunction

  // Monitor: checks every handshake against the queue and stall stability.
  logic p_stall = 1'b0;
  row_t p_data;
  idx_t p_idx;

  always @(negedge clk) begin
    row_t e;
    if (!rst_n) begin
      p_stall = 1'b0;
    end else begin
      if (p_stall) begin
        check("stall_valid", 64'(row_if.row_valid), 64'd1);
        check("stall_data", 64'(row_if.row_data), 64'(p_data));
        check("stall_idx", 64'(row_if.row_idx), 64'(p_idx));
      end
      if (row_if.row_valid && row_if.row_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 64'(row_if.row_data), 64'(e));
        end
        check("beat_idx", 64'(row_if.row_idx), 64'(hs_count));
        check("beat_last", 64'(row_if.row_last), 64'(hs_count == N - 1));
        if (hs_count < N) got_beats[hs_count] = row_if.row_data;
        hs_count++;
      end
      p_stall = row_if.row_valid && !row_if.row_ready;
      p_data  = row_if.row_data;
      p_idx   = row_if.row_idx;
    end
  end

  // Driver: one full transfer from IDLE; optional stall and start/m_in disturbance.
  task automatic transfer(input mat_t m, input logic ovf, input int stall_beat,
                          input int stall_len, input logic disturb);
    int   cycles;
    int   stalled;
    logic seen_done;
    for (int j = 0; j < N; j++) exp_q.push_back(model_beat(m, j));
    hs_count = 0;
    start = 1'b1;
    m_in = m;
    ovf_in = ovf;
    row_if.row_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("accept_state", 64'(dbg_state), 64'(SEND));
    check("ovf_latched", 64'(ovf_out), 64'(ovf));
    cycles = 0;
    stalled = 0;
    seen_done = 1'b0;
    while (!seen_done && cycles < 100) begin
      if (hs_count == stall_beat && stalled < stall_len) begin
        row_if.row_ready = 1'b0;
        stalled++;
      end else begin
        row_if.row_ready = ($urandom_range(0, 1) == 0) ? 1'b1 : 1'b1;
      end
      if (disturb && cycles == 2) begin
        start = 1'b1;
        m_in = ~m;
        ovf_in = ~ovf;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
      seen_done = done;
    end
    start = 1'b0;
    row_if.row_ready = 1'b1;
    check("done_seen", 64'(seen_done), 64'd1);
    check("xfer_cycles", 64'(cycles), 64'(N + stall_len));
    check("fin_busy", 64'(busy), 64'd0);
    check("fin_valid", 64'(row_if.row_valid), 64'd0);
    check("beats_sent", 64'(hs_count), 64'(N));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("ovf_hold", 64'(ovf_out), 64'(ovf));
    if (disturb) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_in = mat_random();
    check("done_width", 64'(done), 64'd0);
    check("idle_state", 64'(dbg_state), 64'(IDLE));
    check("idle_valid", 64'(row_if.row_valid), 64'd0);
    check("idle_ovf_hold", 64'(ovf_out), 64'(ovf));
    exp_q.delete();
  endtask

  typedef struct {
    mat_t m;
    logic ovf;
    int   sel;
    row_t exp_beat;
    logic exp_ovf;
  } vec_t;

  vec_t vecs[4];

  initial begin
    mat_t m_plan;
    mat_t m_neg;
    mat_t m_r10;
    m_plan = {40'h01_03_02_05_00, 160'h0};
    m_neg  = {40'h80_00_00_00_00, 160'h0};
    m_r10  = mat_rule10();
`ifdef MAT_ROW_STREAMER_COLMAJOR_EN
    vecs[0] = '{m_plan, 1'b0, 0, 40'h01_00_00_00_00, 1'b0};
    vecs[1] = '{m_neg,  1'b1, 0, 40'h80_00_00_00_00, 1'b1};
    vecs[2] = '{m_r10,  1'b0, 1, 40'h01_0B_15_1F_29, 1'b0};
    vecs[3] = '{m_r10,  1'b1, 4, 40'h04_0E_18_22_2C, 1'b1};
`else
    vecs[0] = '{m_plan, 1'b0, 0, 40'h01_03_02_05_00, 1'b0};
    vecs[1] = '{m_neg,  1'b1, 0, 40'h80_00_00_00_00, 1'b1};
    vecs[2] = '{m_r10,  1'b0, 1, 40'h0A_0B_0C_0D_0E, 1'b0};
    vecs[3] = '{m_r10,  1'b1, 4, 40'h28_29_2A_2B_2C, 1'b1};
`endif
    row_if.row_ready = 1'b1;

    // Reset values
    #1;
    check("rst_valid", 64'(row_if.row_valid), 64'd0);
    check("rst_data", 64'(row_if.row_data), 64'd0);
    check("rst_idx", 64'(row_if.row_idx), 64'd0);
    check("rst_last", 64'(row_if.row_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ovf", 64'(ovf_out), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors
    for (int v = 0; v < 4; v++) begin
      transfer(vecs[v].m, vecs[v].ovf, 0, 0, 1'b0);
      check("table_beat", 64'(got_beats[vecs[v].sel]), 64'(vecs[v].exp_beat));
      check("table_ovf", 64'(ovf_out), 64'(vecs[v].exp_ovf));
      repeat (2) @(posedge clk);
      #1;
      check("table_ovf_idle", 64'(ovf_out), 64'(vecs[v].exp_ovf));
    end

    // Stall of 3 cycles on beat 2: 8-cycle transfer
    transfer(m_plan ^ mat_rule10(), 1'b0, 2, 3, 1'b0);

    // start pulses and m_in/ovf_in changes while sending and in FIN
    transfer(mat_rule10(), 1'b1, 1, 1, 1'b1);

    // Back-to-back: next start accepted in the cycle after done
    transfer(m_neg, 1'b0, 0, 0, 1'b0);
    transfer(m_plan, 1'b1, 4, 2, 1'b0);

    // Reset asserted mid-transfer
    for (int j = 0; j < N; j++) exp_q.push_back(model_beat(m_plan, j));
    hs_count = 0;
    start = 1'b1;
    m_in = m_plan;
    ovf_in = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(row_if.row_valid), 64'd0);
    check("mid_rst_data", 64'(row_if.row_data), 64'd0);
    check("mid_rst_idx", 64'(row_if.row_idx), 64'd0);
    check("mid_rst_last", 64'(row_if.row_last), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_ovf", 64'(ovf_out), 64'd0);
    check("mid_rst_state", 64'(dbg_state), 64'(IDLE));
    exp_q.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_rst_done", 64'(done), 64'd0);
      check("post_rst_state", 64'(dbg_state), 64'(IDLE));
    end

    // Randomized transfers
    for (int t = 0; t < 25; t++) begin
      transfer(mat_random(), 1'($urandom_range(0, 1)), $urandom_range(0, 4),
               $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mat_row_streamer.md
# mat_row_streamer

Output-side streamer of the matrix coprocessor: captures a complete 5x5 signed 8-bit result matrix and its overflow flag from an operation unit, then transmits it one 40-bit row per beat to the HPS-facing bus. It uses a valid/ready handshake. It is the producer of the same 40-bit row format the operation units consume, with row element 0 in bits [39:32] and element 4 in bits [7:0].

## Interface
- N, 5, matrix dimension (rows = columns = elements per row)
- ELEM_W, 8, signed element width; row width = N*ELEM_W, matrix width = N*N*ELEM_W
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle capture request, honoured only in IDLE
- m_in  in  200  matrix; row r at bits [199-40r -: 40], element c of row at [39-8c -: 8] within it
- ovf_in  in  1  overflow flag of the operation that produced m_in
- row_valid  out  1  row_data/row_idx/row_last are valid
- row_ready  in  1  consumer accepts the current beat
- row_data  out  40  current row (or column, see Configuration)
- row_idx  out  3  beat index 0..4
- row_last  out  1  high with row_valid on beat 4
- busy  out  1  high while the matrix is captured and not yet fully sent
- done  out  1  one-cycle pulse after final handshake
- ovf_out  out  1  captured ovf_in, held until next accepted start

## Operation
- States: IDLE, SEND, FIN.
- IDLE: row_valid=0, busy=0. If start=1, latch m_in into the buffer, latch ovf_in into ovf_out, set idx=0, go SEND.
- SEND: row_valid=1, busy=1, row_data=beat idx, row_last=(idx==4).
  - Handshake when row_valid && row_ready.
  - On handshake with idx<4: idx+1.
  - On handshake with idx==4: go FIN.
- FIN: busy=0, row_valid=0, done=1 for exactly one cycle, then IDLE. start in FIN is ignored.
- start in SEND or FIN is ignored. The buffer and ovf_out are not disturbed.
- While row_valid && !row_ready, row_data, row_idx and row_last hold stable. row_valid never drops without a handshake.
- Changes on m_in or ovf_in after capture have no effect on the beats.
- No arithmetic: data passes bit-exact. Sign is preserved, so -128 = 8'h80 passes unchanged.

## Timing
- Reset values: row_valid=0, row_data=0, row_idx=0, row_last=0, busy=0, done=0, ovf_out=0, buffer=0, state IDLE.
- start sampled at edge k: row_valid=1 with beat 0 from edge k onward.
- With row_ready held high: beats at edges k+1..k+5 (one per cycle), and done high between edges k+5 and k+6.
- Each low-ready cycle stalls by one cycle.
- Earliest next start is accepted one cycle after done.
- rst_n asserted mid-transfer: immediate return to reset values; the partial matrix is discarded and no done pulse is issued.

## Configuration
- MAT_ROW_STREAMER_COLMAJOR_EN defined: beat j carries column j (transpose order).
  - Element i of the beat is matrix[i][j], placed at [39-8i -: 8].
  - row_idx then denotes the column index.
- Undefined: beat j carries row j unchanged (row-major).
- The handshake and timing are identical in both builds.

## Structure
- Shared package mat_pkg holds N, ELEM_W, ROW_W=40, MAT_W=200, row/matrix typedefs, and the state enum (IDLE, SEND, FIN). Operation units use the same package.
- One natural sub-module: mat_beat_select. It is combinational: given the buffer and idx, it returns the row or column slice. The COLMAJOR variant lives inside it.

## Test plan
- Reset with rst_n=0 during SEND, then release: all outputs 0, state IDLE, no done pulse.
- m_in rows [1,3,2,5,0],[0..],…, ovf_in=0, start, ready=1: five beats, idx 0..4, beat0=40'h01_03_02_05_00, row_last only on beat 4, then done pulse on the next cycle.
- Stall: ready low for 3 cycles on beat 2: row_data/idx frozen and row_valid held. The total transfer takes 8 cycles.
- First row [-128,0,0,0,0] with ovf_in=1: beat0=40'h80_00_00_00_00, and ovf_out=1 until the next start.
- start pulsed and m_in changed mid-SEND: ignored, and the original beats complete.
- COLMAJOR build with matrix[i][j]=10i+j: beat1=40'h01_0B_15_1F_29.
